main_file_mem_copy_master: RTL and testbench
============================================

Name: main_file_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one on-chip memory region to another.
- Issues single-word reads, then single-word writes, toward the on-chip memory slave (13-bit word address, 4-bit byteenable).
- Sits beside the Nios/CPU in main_file, is started through a small command port, and frees the CPU from word-by-word copies of frame/tracking buffers.

Parameters:
- ADDR_W, 13, word-address width of the master port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- LEN_W, 13, width of the word-count field.
- READ_LATENCY, 1, fixed slave read latency in cycles after read acceptance (1..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle command strobe; accepted only when busy=0.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- avm_address  out  ADDR_W  master word address.
- avm_byteenable  out  DATA_W/8  always all-ones.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Clock and reset: single clock (clk). Reset is synchronous, active-low (reset_n).
- Reset values: state=IDLE, busy=0, done=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0. avm_byteenable is constant all-ones.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start=1 with length!=0: latch src, dst and length into cur_src, cur_dst and remaining; go to RD_REQ.
  - start=1 with length=0: go to DONE; no bus traffic.
- RD_REQ:
  - avm_read=1, avm_address=cur_src.
  - Hold address and read stable while avm_waitrequest=1.
  - On the cycle read=1 and waitrequest=0, the read is accepted: deassert read, load lat_cnt=READ_LATENCY-1, go to RD_WAIT.
- RD_WAIT:
  - lat_cnt counts down to 0.
  - On the cycle READ_LATENCY after acceptance, capture avm_readdata into the data register; go to WR_REQ.
  - For READ_LATENCY=1, capture occurs on the first RD_WAIT cycle.
- WR_REQ:
  - avm_write=1, avm_address=cur_dst, avm_writedata=the captured word.
  - Hold all outputs stable while waitrequest=1.
  - On acceptance: cur_src+1, cur_dst+1, remaining-1.
  - If remaining was 1, go to DONE; else go to RD_REQ.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- read and write are never asserted in the same cycle.
- Back-to-back timing: with waitrequest=0 and READ_LATENCY=1, one word costs 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- Addresses wrap modulo 2^ADDR_W (0x1FFF+1 -> 0x0000); no error is flagged.
- Overlapping src/dst ranges: copy is strictly ascending, single word at a time. The result is defined only when dst<=src or the ranges are disjoint.
- start while busy=1 is ignored; no queuing.
- start in the DONE cycle is ignored.
- reset_n low mid-transfer: next edge returns to reset values; the pending bus request is dropped. Slave rows already written stay written.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_W-1:0].
  - checksum is cleared on accepted start.
  - checksum += each captured read word, modulo 2^DATA_W.
  - checksum is stable and valid from the done pulse until the next accepted start; reset value 0.
- When undefined: no port and no adder; behaviour is otherwise identical.

Decomposition:
- Package main_file_mem_copy_pkg:
  - State enum type.
  - Default-width localparams.
  - BE_ALL constant (all-ones byteenable).
- One natural sub-module, main_file_mem_copy_lat_cnt: the read-latency down-counter with load/expire. The FSM and address counters stay in the top.

Test Plan:
- Basic copy:
  - Preload mem[0x0100..0x0103]=0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - start src=0x0100 dst=0x0200 len=4, waitrequest=0.
  - Expect mem[0x0200..0x0203] equal to the source, done pulse at cycle 1+4*3, busy high for 12 cycles.
- Waitrequest stall:
  - Hold waitrequest=1 for 5 cycles on the first read and 3 cycles on the first write.
  - Expect address/read/write/writedata stable throughout, correct data, done 8 cycles later than the no-stall case.
- Zero length:
  - start len=0.
  - Expect done the next cycle and no avm_read/avm_write ever asserted.
- Wrap and ignored start:
  - src=0x1FFE dst=0x0010 len=3; a second start is pulsed mid-copy.
  - Expect reads at 0x1FFE, 0x1FFF, 0x0000; the second start has no effect.
- Reset mid-copy:
  - Assert reset_n=0 during WR_REQ of word 2 of 8.
  - Expect all outputs at reset values the next edge, dst words 0..1 written, word 2 untouched.
- READ_LATENCY=3 with MEM_COPY_CHECKSUM_EN:
  - Copy words 1,2,3.
  - Expect capture 3 cycles after acceptance and checksum=6 at done.

Source files
------------

// File: rtl/main_file_mem_copy_pkg.sv
// Shared types and default widths for the memory-copy master.
package main_file_mem_copy_pkg;

    localparam int unsigned ADDR_W_DEF       = 13;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned LEN_W_DEF        = 13;
    localparam int unsigned READ_LATENCY_DEF = 1;
    localparam int unsigned BE_W_DEF         = DATA_W_DEF / 8;

    // Every transfer is a full word.
    localparam logic [BE_W_DEF-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/main_file_mem_copy_if.sv
// Avalon-MM master/slave bus between the copy engine and on-chip memory.
interface main_file_mem_copy_if
    import main_file_mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/main_file_mem_copy_lat_cnt.sv
// Read-latency down-counter: loaded at read acceptance, expires when the
// slave's read data is due on the bus.
module main_file_mem_copy_lat_cnt
    import main_file_mem_copy_pkg::*;
#(
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic tick,
    output logic expired_c
);
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(READ_LATENCY - 1);

    logic [CNT_W-1:0] cnt_q;

    // Load on acceptance, count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/main_file_mem_copy_master.sv
// Avalon-MM copy engine: moves LENGTH words from SRC to DST one word at a
// time (single read, then single write). Optional running checksum of the
// words read is enabled with `define MEM_COPY_CHECKSUM_EN.
module main_file_mem_copy_master
    import main_file_mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned LEN_W        = LEN_W_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    main_file_mem_copy_if.master avm
);
    localparam int unsigned BE_W = DATA_W / 8;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] cur_src_q,   cur_src_d;
    logic [ADDR_W-1:0] cur_dst_q,   cur_dst_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] address_q,   address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              read_q,  read_d;
    logic              write_q, write_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic lat_load;
    logic lat_tick;
    logic lat_expired_c;

    main_file_mem_copy_lat_cnt #(
        .READ_LATENCY (READ_LATENCY)
    ) u_lat_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (lat_load),
        .tick      (lat_tick),
        .expired_c (lat_expired_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? RD_REQ : DONE;
                end
            end
            RD_REQ: begin
                if (!avm.waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_expired_c) state_d = WR_REQ;
            end
            WR_REQ: begin
                if (!avm.waitrequest) begin
                    state_d = (remaining_q == LEN_W'(1)) ? DONE : RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and next bus outputs; bus outputs are derived from the state
    // being entered so they line up with the registered state.
    always_comb begin
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        lat_load    = 1'b0;
        lat_tick    = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (length != '0) begin
                        cur_src_d   = src_addr;
                        cur_dst_d   = dst_addr;
                        remaining_d = length;
                    end
                end
            end
            RD_REQ: begin
                if (!avm.waitrequest) lat_load = 1'b1;
            end
            RD_WAIT: begin
                if (lat_expired_c) begin
                    writedata_d = avm.readdata;
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d = csum_q + avm.readdata;
`endif
                end else begin
                    lat_tick = 1'b1;
                end
            end
            WR_REQ: begin
                if (!avm.waitrequest) begin
                    cur_src_d   = cur_src_q + ADDR_W'(1);
                    cur_dst_d   = cur_dst_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                end
            end
            default: ;
        endcase

        unique case (state_d)
            RD_REQ: begin
                read_d    = 1'b1;
                address_d = cur_src_d;
                busy_d    = 1'b1;
            end
            RD_WAIT: busy_d = 1'b1;
            WR_REQ: begin
                write_d   = 1'b1;
                address_d = cur_dst_d;
                busy_d    = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm.address    = address_q;
    assign avm.byteenable = BE_W'(BE_ALL);
    assign avm.read       = read_q;
    assign avm.write      = write_q;
    assign avm.writedata  = writedata_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum       = csum_q;
`endif

endmodule

// File: tb/tb_main_file_mem_copy_master.sv
// Directed bench for the memory-copy master: one instance with read latency 1
// and one with read latency 3, each backed by a small Avalon memory model.
module tb_main_file_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- latency-1 instance ----------------
    logic        start;
    logic [12:0] src_addr, dst_addr;
    logic [12:0] length;
    logic        busy, done;
    logic        ws;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    main_file_mem_copy_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    main_file_mem_copy_master #(.READ_LATENCY(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
`ifdef MEM_COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .avm      (bus.master)
    );

    logic [31:0] mem [0:8191];
    logic        pl_we;
    logic [12:0] pl_a;
    logic [31:0] pl_d;
    logic        rv1;
    logic [12:0] ra1;

    // Memory model, read latency 1; read data is poisoned unless due.
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (bus.write && !ws) mem[bus.address] <= bus.writedata;
        rv1 <= reset_n && bus.read && !ws;
        ra1 <= bus.address;
    end
    assign bus.waitrequest = ws;
    assign bus.readdata    = rv1 ? mem[ra1] : 32'hBAD0BAD0;

    // ---------------- latency-3 instance ----------------
    logic        start3;
    logic        busy3, done3;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum3;
`endif

    main_file_mem_copy_if #(.ADDR_W(13), .DATA_W(32)) bus3 ();

    main_file_mem_copy_master #(.READ_LATENCY(3)) dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start3),
        .src_addr (13'h0001),
        .dst_addr (13'h0008),
        .length   (13'd3),
        .busy     (busy3),
        .done     (done3),
`ifdef MEM_COPY_CHECKSUM_EN
        .checksum (checksum3),
`endif
        .avm      (bus3.master)
    );

    logic [31:0] mem3 [0:8191];
    logic        pl3_we;
    logic [12:0] p0, p1, p2;
    logic        v0, v1, v2;

    // Memory model, read latency 3, never stalls.
    always @(posedge clk) begin
        if (pl3_we) mem3[pl_a] <= pl_d;
        else if (bus3.write) mem3[bus3.address] <= bus3.writedata;
        v0 <= reset_n && bus3.read;
        v1 <= v0;
        v2 <= v1;
        p0 <= bus3.address;
        p1 <= p0;
        p2 <= p1;
    end
    assign bus3.waitrequest = 1'b0;
    assign bus3.readdata    = v2 ? mem3[p2] : 32'hBAD0BAD0;

    // ---------------- helpers ----------------
    logic [12:0] rd_addrs [0:7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit sel3, input logic [12:0] a, input logic [31:0] d);
        pl_a = a;
        pl_d = d;
        if (sel3) pl3_we = 1'b1; else pl_we = 1'b1;
        tick();
        pl_we  = 1'b0;
        pl3_we = 1'b0;
    endtask

    task automatic kick(input logic [12:0] s, input logic [12:0] d, input logic [12:0] n);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Runs the latency-1 copy until done; optional stalls and a mid-copy start.
    task automatic run_copy(input int rd_hold, input int wr_hold, input int inject_at,
                            output int cyc, output int busy_n, output int rd_n,
                            output int wr_n, output bit both, output bit stable);
        int rd_seen, wr_seen;
        logic [12:0] sv_ra, sv_wa;
        logic [31:0] sv_wd;
        cyc = 0; busy_n = 0; rd_n = 0; wr_n = 0; both = 1'b0; stable = 1'b1;
        rd_seen = 0; wr_seen = 0; sv_ra = '0; sv_wa = '0; sv_wd = '0;
        while (!done && cyc < 200) begin
            ws = 1'b0;
            if (bus.read) begin
                if (rd_seen == 0) sv_ra = bus.address;
                else if (rd_seen <= rd_hold && bus.address !== sv_ra) stable = 1'b0;
                ws = (rd_seen < rd_hold);
                rd_seen++;
            end
            if (bus.write) begin
                if (wr_seen == 0) begin
                    sv_wa = bus.address;
                    sv_wd = bus.writedata;
                end else if (wr_seen <= wr_hold &&
                             (bus.address !== sv_wa || bus.writedata !== sv_wd)) begin
                    stable = 1'b0;
                end
                ws = (wr_seen < wr_hold);
                wr_seen++;
            end
            if (busy) busy_n++;
            if (bus.read && bus.write) both = 1'b1;
            if (bus.read && !ws) begin
                if (rd_n < 8) rd_addrs[rd_n] = bus.address;
                rd_n++;
            end
            if (bus.write && !ws) wr_n++;
            if (cyc == inject_at) begin
                src_addr = 13'h0050; dst_addr = 13'h0070; length = 13'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        ws    = 1'b0;
    endtask

    int cyc, busy_n, rd_n, wr_n, acc, w1;
    bit both, stable, any_rw;

    initial begin
        reset_n = 1'b0; start = 1'b0; start3 = 1'b0; ws = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        pl_we = 1'b0; pl3_we = 1'b0; pl_a = '0; pl_d = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_busy",    64'(busy), 64'(0));
        check("rst_done",    64'(done), 64'(0));
        check("rst_read",    64'(bus.read), 64'(0));
        check("rst_write",   64'(bus.write), 64'(0));
        check("rst_address", 64'(bus.address), 64'(0));
        check("rst_wdata",   64'(bus.writedata), 64'(0));
        check("byteenable",  64'(bus.byteenable), 64'hF);
        check("byteenable3", 64'(bus3.byteenable), 64'hF);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'(0));
`endif
        reset_n = 1'b1;
        tick();

        // Basic copy, 4 words, no stalls
        preload(1'b0, 13'h0100, 32'h11111111);
        preload(1'b0, 13'h0101, 32'h22222222);
        preload(1'b0, 13'h0102, 32'h33333333);
        preload(1'b0, 13'h0103, 32'h44444444);
        kick(13'h0100, 13'h0200, 13'd4);
        check("basic_first_read", 64'({bus.read, bus.address}), 64'({1'b1, 13'h0100}));
        run_copy(0, 0, -1, cyc, busy_n, rd_n, wr_n, both, stable);
        check("basic_done_cycle", 64'(cyc), 64'(12));
        check("basic_busy_cycles", 64'(busy_n), 64'(12));
        check("basic_busy_at_done", 64'(busy), 64'(0));
        check("basic_rw_overlap", 64'(both), 64'(0));
        check("basic_reads", 64'(rd_n), 64'(4));
        check("basic_writes", 64'(wr_n), 64'(4));
`ifdef MEM_COPY_CHECKSUM_EN
        check("basic_checksum", 64'(checksum), 64'hAAAAAAAA);
`endif
        tick();
        check("basic_done_pulse", 64'(done), 64'(0));
        check("basic_dst0", 64'(mem[13'h0200]), 64'h11111111);
        check("basic_dst1", 64'(mem[13'h0201]), 64'h22222222);
        check("basic_dst2", 64'(mem[13'h0202]), 64'h33333333);
        check("basic_dst3", 64'(mem[13'h0203]), 64'h44444444);

        // Waitrequest stalls: 5 on first read, 3 on first write
        preload(1'b0, 13'h0300, 32'hA5A50001);
        preload(1'b0, 13'h0301, 32'hA5A50002);
        kick(13'h0300, 13'h0400, 13'd2);
        run_copy(5, 3, -1, cyc, busy_n, rd_n, wr_n, both, stable);
        check("stall_done_cycle", 64'(cyc), 64'(14));
        check("stall_stable", 64'(stable), 64'(1));
        tick();
        check("stall_dst0", 64'(mem[13'h0400]), 64'hA5A50001);
        check("stall_dst1", 64'(mem[13'h0401]), 64'hA5A50002);

        // Zero length: done next cycle, no bus traffic
        kick(13'h0100, 13'h0700, 13'd0);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        any_rw = bus.read || bus.write;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.read || bus.write) any_rw = 1'b1;
        end
        check("zero_no_traffic", 64'(any_rw), 64'(0));
        check("zero_done_pulse", 64'(done), 64'(0));

        // Address wrap, start mid-copy ignored, start in DONE cycle ignored
        preload(1'b0, 13'h1FFE, 32'hAAAA0001);
        preload(1'b0, 13'h1FFF, 32'hAAAA0002);
        preload(1'b0, 13'h0000, 32'hAAAA0003);
        kick(13'h1FFE, 13'h0010, 13'd3);
        run_copy(0, 0, 4, cyc, busy_n, rd_n, wr_n, both, stable);
        check("wrap_done_cycle", 64'(cyc), 64'(9));
        check("wrap_reads", 64'(rd_n), 64'(3));
        check("wrap_rd0", 64'(rd_addrs[0]), 64'h1FFE);
        check("wrap_rd1", 64'(rd_addrs[1]), 64'h1FFF);
        check("wrap_rd2", 64'(rd_addrs[2]), 64'h0000);
        src_addr = 13'h0060; dst_addr = 13'h0080; length = 13'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_ignored", 64'({busy, bus.read}), 64'(0));
        check("wrap_dst0", 64'(mem[13'h0010]), 64'hAAAA0001);
        check("wrap_dst1", 64'(mem[13'h0011]), 64'hAAAA0002);
        check("wrap_dst2", 64'(mem[13'h0012]), 64'hAAAA0003);
        tick();

        // Reset during the write of word 2 of 8
        for (int i = 0; i < 8; i++) begin
            preload(1'b0, 13'(13'h0500 + i), 32'h50000000 + 32'(i));
            preload(1'b0, 13'(13'h0600 + i), 32'hDEAD0000 + 32'(i));
        end
        kick(13'h0500, 13'h0600, 13'd8);
        for (int i = 0; i < 8; i++) tick();
        check("midrst_in_write", 64'({bus.write, bus.address}), 64'({1'b1, 13'h0602}));
        reset_n = 1'b0;
        ws      = 1'b1;
        tick();
        check("midrst_outputs", 64'({busy, done, bus.read, bus.write}), 64'(0));
        check("midrst_address", 64'(bus.address), 64'(0));
        check("midrst_wdata",   64'(bus.writedata), 64'(0));
        reset_n = 1'b1;
        ws      = 1'b0;
        tick();
        check("midrst_idle", 64'({busy, bus.read, bus.write}), 64'(0));
        check("midrst_dst0", 64'(mem[13'h0600]), 64'h50000000);
        check("midrst_dst1", 64'(mem[13'h0601]), 64'h50000001);
        check("midrst_dst2", 64'(mem[13'h0602]), 64'hDEAD0002);

        // Read latency 3: copy 1,2,3 from 1..3 to 8..10
        preload(1'b1, 13'h0001, 32'd1);
        preload(1'b1, 13'h0002, 32'd2);
        preload(1'b1, 13'h0003, 32'd3);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0; acc = -1; w1 = -1;
        while (!done3 && cyc < 200) begin
            if (bus3.read && acc < 0) acc = cyc;
            if (bus3.write && w1 < 0) w1 = cyc;
            tick();
            cyc++;
        end
        check("rl3_done_cycle", 64'(cyc), 64'(15));
        check("rl3_capture_delay", 64'(w1 - acc), 64'(4));
        check("rl3_busy_at_done", 64'(busy3), 64'(0));
`ifdef MEM_COPY_CHECKSUM_EN
        check("rl3_checksum", 64'(checksum3), 64'(6));
`endif
        tick();
        tick();
`ifdef MEM_COPY_CHECKSUM_EN
        check("rl3_checksum_hold", 64'(checksum3), 64'(6));
`endif
        check("rl3_dst0", 64'(mem3[13'h0008]), 64'(1));
        check("rl3_dst1", 64'(mem3[13'h0009]), 64'(2));
        check("rl3_dst2", 64'(mem3[13'h000A]), 64'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
